// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing, colour and height definitions for VGA pixel sources
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 480;
  localparam int V_TOTAL   = 525;
  localparam int CELL_W    = 20;
  localparam int LOOKAHEAD = 2;

  localparam int BAND_LO  = 160;
  localparam int BAND_MID = 320;

  localparam logic [7:0] COL_BG  = 8'h00;
  localparam logic [7:0] COL_LO  = 8'h38;
  localparam logic [7:0] COL_MID = 8'h3F;
  localparam logic [7:0] COL_HI  = 8'h07;

  typedef logic [8:0] height_t;

  localparam height_t MAX_HEIGHT = 9'd480;

  typedef struct packed {
    logic [4:0] col;
    logic [4:0] pic;
  } cell_pos_t;

  // Absolute cell position, used whenever the column counters cannot simply step.
  function automatic cell_pos_t cell_seed(input logic [9:0] th);
    cell_pos_t r;
    if (th >= 10'(H_VISIBLE)) begin
      r.col = 5'(H_VISIBLE / CELL_W - 1);
      r.pic = 5'(CELL_W - 1);
    end else begin
      // th*205/4096 equals th/20 exactly for every th below 640
      r.col = 5'((18'(th) * 18'd205) >> 12);
      r.pic = 5'(th - 10'(r.col) * 10'(CELL_W));
    end
    return r;
  endfunction

  function automatic logic [7:0] band_colour(input height_t rb);
    if (rb < height_t'(BAND_LO)) begin
      return COL_LO;
    end else if (rb < height_t'(BAND_MID)) begin
      return COL_MID;
    end
    return COL_HI;
  endfunction

endpackage

// File: rtl/vga_lookahead_pos.sv
// rtl/vga_lookahead_pos.sv - stage-1 position of the pixel LOOKAHEAD cycles ahead of hc/vc
module vga_lookahead_pos
  import vga_pkg::*;
(
  input  logic       vgaclk,
  input  logic       rst_n,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  output logic [4:0] col,
  output logic [4:0] pic,
  output height_t    rb,
  output logic       visible
);

  logic [10:0] th_sum;
  logic [9:0]  th;
  logic [9:0]  tv;
  logic [9:0]  th_q;
  cell_pos_t   nxt;

  always_comb begin
    th_sum = {1'b0, hc} + 11'(LOOKAHEAD);
    th     = th_sum[9:0];
    tv     = vc;
    if (th_sum >= 11'(H_TOTAL)) begin
      th = 10'(th_sum - 11'(H_TOTAL));
      tv = (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
    end
  end

  // Step the counters when th advanced by one; reseed after reset or any jump in hc.
  always_comb begin
    nxt = cell_seed(th);
    if (th == 10'd0) begin
      nxt = '0;
    end else if (th >= 10'(H_VISIBLE)) begin
      nxt.col = 5'(H_VISIBLE / CELL_W - 1);
      nxt.pic = 5'(CELL_W - 1);
    end else if (th == th_q + 10'd1) begin
      if (pic == 5'(CELL_W - 1)) begin
        nxt.col = col + 5'd1;
        nxt.pic = 5'd0;
      end else begin
        nxt.col = col;
        nxt.pic = pic + 5'd1;
      end
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      th_q    <= '0;
      col     <= '0;
      pic     <= '0;
      rb      <= '0;
      visible <= 1'b0;
    end else begin
      th_q    <= th;
      col     <= nxt.col;
      pic     <= nxt.pic;
      rb      <= height_t'(10'(V_VISIBLE - 1) - tv);
      visible <= (th < 10'(H_VISIBLE)) && (tv < 10'(V_VISIBLE));
    end
  end

endmodule

// File: rtl/vga_bar_renderer.sv
// rtl/vga_bar_renderer.sv - double-buffered spectrum bar renderer feeding the VGA timing generator
module vga_bar_renderer
  import vga_pkg::*;
#(
  parameter int SAMPLES   = 32,
  parameter int WIDTH     = 32,
  parameter int MAG_SHIFT = 23
) (
  input  logic             vgaclk,
  input  logic             rst_n,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [4:0]       bin_idx,
  input  logic [WIDTH-1:0] bin_mag,
  output logic [7:0]       colorPacking,
  output logic             frame_swap
);

  height_t          shadow_h [SAMPLES];
  height_t          active_h [SAMPLES];
  logic [WIDTH-1:0] mag_sh;
  height_t          wr_height;
  logic             wr_en;
  logic             swap_now;

  logic [4:0] s1_col;
  logic [4:0] s1_pic;
  height_t    s1_rb;
  logic       s1_visible;
  logic [7:0] pix_next;

  // The copy happens at the first line of vertical blanking, so no visible pixel sees it mid-frame.
  assign swap_now   = rst_n && (vc == 10'(V_VISIBLE)) && (hc == 10'd0);
  assign frame_swap = swap_now;
  assign bin_ready  = !swap_now;

  assign mag_sh    = bin_mag >> MAG_SHIFT;
  assign wr_height = (mag_sh > WIDTH'(MAX_HEIGHT)) ? MAX_HEIGHT : mag_sh[8:0];
  assign wr_en     = bin_valid && bin_ready && ({1'b0, bin_idx} < 6'(SAMPLES));

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SAMPLES; i++) begin
        shadow_h[i] <= '0;
        active_h[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        shadow_h[bin_idx] <= wr_height;
      end
      if (swap_now) begin
        for (int i = 0; i < SAMPLES; i++) begin
          active_h[i] <= shadow_h[i];
        end
      end
    end
  end

  vga_lookahead_pos u_pos (
    .vgaclk  (vgaclk),
    .rst_n   (rst_n),
    .hc      (hc),
    .vc      (vc),
    .col     (s1_col),
    .pic     (s1_pic),
    .rb      (s1_rb),
    .visible (s1_visible)
  );

  always_comb begin
    pix_next = COL_BG;
    if (s1_visible && (s1_pic != 5'(CELL_W - 1)) && (s1_rb < active_h[s1_col])) begin
      pix_next = band_colour(s1_rb);
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      colorPacking <= COL_BG;
    end else begin
      colorPacking <= pix_next;
    end
  end

endmodule

// File: tb/tb_vga_bar_renderer.sv
// tb/tb_vga_bar_renderer.sv - scoreboard bench for vga_bar_renderer
module tb_vga_bar_renderer;

  logic        vgaclk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  hc = '0;
  logic [9:0]  vc = '0;
  logic        bin_valid = 1'b0;
  logic [4:0]  bin_idx = '0;
  logic [31:0] bin_mag = '0;
  logic        bin_ready;
  logic        frame_swap;
  logic [7:0]  colorPacking;

  int checks = 0;
  int failures = 0;
  int swap_pulses = 0;
  int nz_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] row_pix[800];
  int m_shadow[32];
  int m_active[32];

  always #20 vgaclk = ~vgaclk;

  vga_bar_renderer #(.SAMPLES(32), .WIDTH(32), .MAG_SHIFT(23)) dut (
    .vgaclk       (vgaclk),
    .rst_n        (rst_n),
    .hc           (hc),
    .vc           (vc),
    .bin_valid    (bin_valid),
    .bin_ready    (bin_ready),
    .bin_idx      (bin_idx),
    .bin_mag      (bin_mag),
    .colorPacking (colorPacking),
    .frame_swap   (frame_swap)
  );

  function automatic int sat_height(input logic [31:0] m);
    int s;
    s = int'(m >> 23);
    return (s > 480) ? 480 : s;
  endfunction

  function automatic logic [7:0] model_pix(input int h, input int v);
    int th, tv, col, p, rb;
    th = h + 2;
    tv = v;
    if (th >= 800) begin
      th = th - 800;
      tv = tv + 1;
      if (tv == 525) tv = 0;
    end
    if (th >= 640 || tv >= 480) return 8'h00;
    col = th / 20;
    p   = th % 20;
    rb  = 479 - tv;
    if (p == 19 || rb >= m_active[col]) return 8'h00;
    if (rb < 160) return 8'h38;
    if (rb < 320) return 8'h3F;
    return 8'h07;
  endfunction

  task automatic cycle_wr(input int h, input int v, input logic valid, input int idx, input logic [31:0] mag);
    logic swap;
    logic [7:0] e;
    @(posedge vgaclk);
    #1;
    hc = 10'(h);
    vc = 10'(v);
    bin_valid = valid;
    bin_idx = 5'(idx);
    bin_mag = mag;
    rst_n = 1'b1;
    swap = (h == 0 && v == 480);
    exp_q.push_back(model_pix(h, v));
    @(negedge vgaclk);
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      checks++;
      if (colorPacking !== e) begin
        failures++;
        if (failures <= 40) $display("FAIL pixel hc=%0d vc=%0d got=%h want=%h", h, v, colorPacking, e);
      end
    end
    checks++;
    if (frame_swap !== swap) begin
      failures++;
      if (failures <= 40) $display("FAIL frame_swap hc=%0d vc=%0d got=%b want=%b", h, v, frame_swap, swap);
    end
    checks++;
    if (bin_ready !== !swap) begin
      failures++;
      if (failures <= 40) $display("FAIL bin_ready hc=%0d vc=%0d got=%b want=%b", h, v, bin_ready, !swap);
    end
    if (frame_swap === 1'b1) swap_pulses++;
    if (colorPacking !== 8'h00) nz_cnt++;
    row_pix[h] = colorPacking;
    if (valid && !swap && idx < 32) m_shadow[idx] = sat_height(mag);
    if (swap) m_active = m_shadow;
  endtask

  task automatic cycle(input int h, input int v);
    cycle_wr(h, v, 1'b0, 0, 32'd0);
  endtask

  task automatic run_row(input int y, input int hend);
    for (int h = 790; h < 800; h++) cycle(h, (y == 0) ? 524 : y - 1);
    nz_cnt = 0;
    for (int h = 0; h <= hend; h++) cycle(h, y);
  endtask

  task automatic run_swap();
    for (int h = 780; h < 800; h++) cycle(h, 479);
    for (int h = 0; h <= 10; h++) cycle(h, 480);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #3;
    checks++;
    if (colorPacking !== 8'h00) begin failures++; $display("FAIL reset_color got=%h want=00", colorPacking); end
    checks++;
    if (frame_swap !== 1'b0) begin failures++; $display("FAIL reset_swap got=%b want=0", frame_swap); end
    checks++;
    if (bin_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bin_ready); end
    for (int i = 0; i < 32; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    repeat (2) @(posedge vgaclk);
  endtask

  task automatic test_blank_frame();
    int p0;
    run_row(0, 799);
    p0 = swap_pulses;
    run_swap();
    checks++;
    if (swap_pulses - p0 != 1) begin failures++; $display("FAIL swap_count got=%0d want=1", swap_pulses - p0); end
    run_row(240, 799);
    checks++;
    if (nz_cnt != 0) begin failures++; $display("FAIL blank_row got=%0d want=0", nz_cnt); end
  endtask

  task automatic test_single_bar();
    cycle_wr(700, 200, 1'b1, 0, 32'd100 << 23);
    run_row(479, 650);
    checks++;
    if (nz_cnt != 0) begin failures++; $display("FAIL preswap_row got=%0d want=0", nz_cnt); end
    run_swap();
    run_row(379, 650);
    checks++;
    if (nz_cnt != 0) begin failures++; $display("FAIL bar0_row379 got=%0d want=0", nz_cnt); end
    run_row(380, 650);
    checks++;
    if (nz_cnt != 19) begin failures++; $display("FAIL bar0_row380 got=%0d want=19", nz_cnt); end
    checks++;
    if (row_pix[19] !== 8'h00) begin failures++; $display("FAIL bar0_gutter got=%h want=00", row_pix[19]); end
    run_row(479, 650);
    checks++;
    if (row_pix[0] !== 8'h38) begin failures++; $display("FAIL bar0_x0 got=%h want=38", row_pix[0]); end
  endtask

  task automatic test_saturate();
    cycle_wr(700, 490, 1'b1, 31, 32'hFFFF_FFFF);
    run_swap();
    run_row(0, 650);
    checks++;
    if (row_pix[625] !== 8'h07) begin failures++; $display("FAIL sat_row0 got=%h want=07", row_pix[625]); end
    checks++;
    if (nz_cnt != 19) begin failures++; $display("FAIL sat_row0_cnt got=%0d want=19", nz_cnt); end
    run_row(160, 650);
    checks++;
    if (row_pix[638] !== 8'h3F) begin failures++; $display("FAIL sat_row160 got=%h want=3F", row_pix[638]); end
    run_row(320, 650);
    checks++;
    if (row_pix[620] !== 8'h38) begin failures++; $display("FAIL sat_row320 got=%h want=38", row_pix[620]); end
    run_row(479, 650);
    checks++;
    if (nz_cnt != 38) begin failures++; $display("FAIL sat_row479_cnt got=%0d want=38", nz_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++)
      cycle_wr(i, 490, 1'b1, i, (i * 20 > 500) ? 32'hFF80_0000 : 32'(i * 20) << 23);
    for (int h = 790; h < 800; h++) cycle_wr(h, 479, 1'b1, 5, 32'd200 << 23);
    cycle_wr(0, 480, 1'b1, 5, 32'd300 << 23);
    cycle_wr(1, 480, 1'b1, 5, 32'd300 << 23);
    for (int h = 2; h <= 10; h++) cycle(h, 480);
    run_row(229, 650);
    checks++;
    if (row_pix[105] !== 8'h00) begin failures++; $display("FAIL race_h200_bg got=%h want=00", row_pix[105]); end
    checks++;
    if (row_pix[305] !== 8'h3F) begin failures++; $display("FAIL b2b_col15 got=%h want=3F", row_pix[305]); end
    run_row(330, 650);
    checks++;
    if (row_pix[105] !== 8'h38) begin failures++; $display("FAIL race_h200_fg got=%h want=38", row_pix[105]); end
    run_swap();
    run_row(229, 650);
    checks++;
    if (row_pix[105] !== 8'h3F) begin failures++; $display("FAIL race_next_frame got=%h want=3F", row_pix[105]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e;
    run_row(200, 299);
    @(posedge vgaclk);
    #1;
    hc = 10'd300;
    vc = 10'd200;
    e = exp_q.pop_front();
    checks++;
    if (colorPacking !== e || e === 8'h00) begin
      failures++;
      $display("FAIL pre_reset_pixel got=%h want=%h", colorPacking, e);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (colorPacking !== 8'h00) begin failures++; $display("FAIL async_clear got=%h want=00", colorPacking); end
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    for (int k = 1; k <= 3; k++) begin
      @(posedge vgaclk);
      #1;
      hc = 10'(300 + k);
      @(negedge vgaclk);
      checks++;
      if (colorPacking !== 8'h00 || bin_ready !== 1'b1) begin
        failures++;
        $display("FAIL in_reset got=%h/%b want=00/1", colorPacking, bin_ready);
      end
    end
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int h = 304; h < 800; h++) cycle(h, 200);
    cycle_wr(0, 490, 1'b1, 15, 32'd300 << 23);
    run_swap();
    run_row(200, 650);
    checks++;
    if (row_pix[300] !== 8'h3F) begin failures++; $display("FAIL post_reset_bar got=%h want=3F", row_pix[300]); end
    checks++;
    if (row_pix[319] !== 8'h00) begin failures++; $display("FAIL post_reset_gutter got=%h want=00", row_pix[319]); end
  endtask

  initial begin
    test_reset();
    test_blank_frame();
    test_single_bar();
    test_saturate();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
